dog_writer: RTL and testbench

- Builds the two difference-of-Gaussian (DoG) images for one octave, in the format the extrema checker reads.
- Streams three Gaussian-blurred 8-bit BRAM images (G0, G1, G2) through one shared read address.
- Computes signed differences first = G1 - G0 and second = G2 - G1.
- Writes both results into two 9-bit signed DoG BRAMs at the same pixel address, one pixel per cycle once the pipeline is full.
- Sits between the Gaussian pyramid stage and the extrema checker. Asserts done when both DoG BRAMs are complete.

---
 rtl/sift_pkg.sv | 20 ++
 rtl/dog_subtract.sv | 47 ++++
 rtl/dog_writer.sv | 151 +++++++++++++++
 tb/tb_dog_writer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Shared SIFT definitions: DoG writer state encoding, pixel-address width
// helper (so read and write sides agree), and default image constants.
package sift_pkg;

  localparam int unsigned SIFT_DIMENSION = 4;
  localparam int unsigned SIFT_BIT_DEPTH = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } dog_state_t;

  // Address width for a square DIMENSION x DIMENSION image, at least 1 bit.
  function automatic int unsigned pix_addr_width(input int unsigned dim);
    return (dim * dim > 1) ? $clog2(dim * dim) : 1;
  endfunction

endpackage

// File: rtl/dog_subtract.sv
// Registered signed subtractor: o_diff = minuend - subtractor on zero-extended
// unsigned inputs. Optional feature macro DOG_THRESHOLD_EN: differences with
// magnitude below ABS_CONTRAST_THRESHOLD are written as zero.
module dog_subtract #(
  parameter int unsigned IN_DEPTH               = 8,
  parameter int unsigned BIT_DEPTH              = 9,
  parameter int unsigned ABS_CONTRAST_THRESHOLD = 4
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        i_valid,
  input  logic [IN_DEPTH-1:0]         i_minuend,
  input  logic [IN_DEPTH-1:0]         i_subtrahend,
  output logic signed [BIT_DEPTH-1:0] o_diff
);

`ifdef DOG_THRESHOLD_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  localparam int unsigned WW = BIT_DEPTH + 1;

  logic signed [BIT_DEPTH-1:0] w_raw;
  logic [WW-1:0]               w_abs;
  logic                        w_small;
  logic signed [BIT_DEPTH-1:0] w_diff;

  // Difference, magnitude and optional low-contrast suppression
  always_comb begin
    w_raw   = $signed({1'b0, i_minuend}) - $signed({1'b0, i_subtrahend});
    w_abs   = w_raw[BIT_DEPTH-1] ? (WW'(0) - {1'b1, w_raw}) : {1'b0, w_raw};
    w_small = (w_abs < WW'(ABS_CONTRAST_THRESHOLD));
    w_diff  = (THRESH_EN && w_small) ? '0 : w_raw;
  end

  // Capture the difference when the source data is valid
  always_ff @(posedge clk) begin
    if (rst_in) begin
      o_diff <= '0;
    end else if (i_valid) begin
      o_diff <= w_diff;
    end
  end

endmodule

// File: rtl/dog_writer.sv
// DoG writer: streams G0/G1/G2 through one shared read address and writes
// G1-G0 and G2-G1 into two signed DoG BRAMs, one pixel per cycle.
// Optional feature macro DOG_THRESHOLD_EN (handled in dog_subtract).
module dog_writer
  import sift_pkg::*;
#(
  parameter int unsigned DIMENSION              = SIFT_DIMENSION,
  parameter int unsigned IN_DEPTH               = 8,
  parameter int unsigned BIT_DEPTH              = SIFT_BIT_DEPTH,
  parameter int unsigned READ_LATENCY           = 2,
  parameter int unsigned ABS_CONTRAST_THRESHOLD = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_in,
  input  logic                                     start,
  output logic [pix_addr_width(DIMENSION)-1:0]     gauss_address,
  input  logic [IN_DEPTH-1:0]                      gauss0_data,
  input  logic [IN_DEPTH-1:0]                      gauss1_data,
  input  logic [IN_DEPTH-1:0]                      gauss2_data,
  output logic [pix_addr_width(DIMENSION)-1:0]     first_address,
  output logic signed [BIT_DEPTH-1:0]              first_data,
  output logic                                     first_we,
  output logic [pix_addr_width(DIMENSION)-1:0]     second_address,
  output logic signed [BIT_DEPTH-1:0]              second_data,
  output logic                                     second_we,
  output logic                                     busy,
  output logic                                     done
);

  localparam int unsigned N  = DIMENSION * DIMENSION;
  localparam int unsigned AW = pix_addr_width(DIMENSION);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  dog_state_t             r_state;
  logic [READ_LATENCY-1:0] r_vpipe;
  logic [AW-1:0]           r_apipe [READ_LATENCY];
  logic                    r_we;
  logic [AW-1:0]           r_wr_addr;

  logic                    w_exit_valid;
  logic [AW-1:0]           w_exit_addr;
  logic                    w_pipe_empty;

  assign w_exit_valid = r_vpipe[READ_LATENCY-1];
  assign w_exit_addr  = r_apipe[READ_LATENCY-1];
  assign w_pipe_empty = (r_vpipe == '0);

  // Control FSM: address sequencing, busy and the done pulse
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state       <= IDLE;
      gauss_address <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            gauss_address <= '0;
            busy          <= 1'b1;
            r_state       <= READ;
          end
        end
        READ: begin
          if (gauss_address == LAST_ADDR) begin
            r_state <= DRAIN;
          end else begin
            gauss_address <= gauss_address + 1'b1;
          end
        end
        DRAIN: begin
          // Pipe empty with a write on the ports means the last pixel is out
          if (w_pipe_empty && r_we) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Valid/address shift register matching the source BRAM read latency
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_vpipe <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_apipe[i] <= '0;
      end
    end else begin
      r_vpipe[0] <= (r_state == READ);
      r_apipe[0] <= gauss_address;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_apipe[i] <= r_apipe[i-1];
      end
    end
  end

  // Write strobe and address, aligned with the registered differences
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_we      <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_we <= w_exit_valid;
      if (w_exit_valid) begin
        r_wr_addr <= w_exit_addr;
      end
    end
  end

  assign first_we       = r_we;
  assign second_we      = r_we;
  assign first_address  = r_wr_addr;
  assign second_address = r_wr_addr;

  dog_subtract #(
    .IN_DEPTH              (IN_DEPTH),
    .BIT_DEPTH             (BIT_DEPTH),
    .ABS_CONTRAST_THRESHOLD(ABS_CONTRAST_THRESHOLD)
  ) u_first (
    .clk         (clk),
    .rst_in      (rst_in),
    .i_valid     (w_exit_valid),
    .i_minuend   (gauss1_data),
    .i_subtrahend(gauss0_data),
    .o_diff      (first_data)
  );

  dog_subtract #(
    .IN_DEPTH              (IN_DEPTH),
    .BIT_DEPTH             (BIT_DEPTH),
    .ABS_CONTRAST_THRESHOLD(ABS_CONTRAST_THRESHOLD)
  ) u_second (
    .clk         (clk),
    .rst_in      (rst_in),
    .i_valid     (w_exit_valid),
    .i_minuend   (gauss2_data),
    .i_subtrahend(gauss1_data),
    .o_diff      (second_data)
  );

endmodule

// File: tb/tb_dog_writer.sv
// Self-checking bench for dog_writer: BRAM models with 2-cycle read latency,
// a write monitor, and a reference model computing DoG values from the
// stored images with plain integer arithmetic.
module tb_dog_writer;

  localparam int DIM = 4;
  localparam int N   = DIM * DIM;
  localparam int RL  = 2;
  localparam int THR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_in = 1'b1;
  logic              start  = 1'b0;
  logic [3:0]        gauss_address;
  logic [7:0]        gauss0_data = '0, gauss1_data = '0, gauss2_data = '0;
  logic [3:0]        first_address, second_address;
  logic signed [8:0] first_data, second_data;
  logic              first_we, second_we, busy, done;

  dog_writer #(
    .DIMENSION             (DIM),
    .IN_DEPTH              (8),
    .BIT_DEPTH             (9),
    .READ_LATENCY          (RL),
    .ABS_CONTRAST_THRESHOLD(THR)
  ) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .start         (start),
    .gauss_address (gauss_address),
    .gauss0_data   (gauss0_data),
    .gauss1_data   (gauss1_data),
    .gauss2_data   (gauss2_data),
    .first_address (first_address),
    .first_data    (first_data),
    .first_we      (first_we),
    .second_address(second_address),
    .second_data   (second_data),
    .second_we     (second_we),
    .busy          (busy),
    .done          (done)
  );

  int checks = 0;
  int failures = 0;

  // Source images and two-stage BRAM read model
  logic [7:0] m0 [N];
  logic [7:0] m1 [N];
  logic [7:0] m2 [N];
  logic [7:0] p0 = '0, p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p0 <= m0[gauss_address];
    p1 <= m1[gauss_address];
    p2 <= m2[gauss_address];
    gauss0_data <= p0;
    gauss1_data <= p1;
    gauss2_data <= p2;
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    int addr;
    int addr2;
    int d1;
    int d2;
    int cyc;
    bit both;
  } wr_t;
  wr_t wq[$];
  int  done_q[$];

  // Write/done monitor sampled away from the active edge
  always @(negedge clk) begin
    if (first_we || second_we)
      wq.push_back('{int'(first_address), int'(second_address),
                     int'(first_data), int'(second_data), edge_cnt,
                     first_we && second_we});
    if (done) done_q.push_back(edge_cnt);
  end

  function automatic int exp_diff(input int a, input int b);
    int d;
    d = a - b;
`ifdef DOG_THRESHOLD_EN
    if ((d < 0 ? -d : d) < THR) d = 0;
`endif
    return d;
  endfunction

  task automatic fill(input int pattern);
    for (int a = 0; a < N; a++) begin
      case (pattern)
        0: begin m0[a] = 8'(a); m1[a] = 8'(2*a); m2[a] = 8'(3*a); end
        1: begin m0[a] = 8'd255; m1[a] = 8'd0; m2[a] = 8'd255; end
        3: begin
          m0[a] = 8'd100;
          case (a)
            0: m1[a] = 8'd97;
            1: m1[a] = 8'd103;
            2: m1[a] = 8'd104;
            3: m1[a] = 8'd96;
            default: m1[a] = 8'($urandom_range(90, 110));
          endcase
          m2[a] = 8'(int'(m1[a]) + $urandom_range(0, 10) - 5);
        end
        default: begin
          m0[a] = 8'($urandom);
          m1[a] = 8'($urandom);
          m2[a] = 8'($urandom);
        end
      endcase
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gauss_address, first_address, second_address} !== '0 ||
        {first_data, second_data} !== '0 ||
        {first_we, second_we, busy, done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_state: ga=%0d fa=%0d sa=%0d fd=%0d sd=%0d we=%b%b busy=%b done=%b, required all zero",
               gauss_address, first_address, second_address, first_data,
               second_data, first_we, second_we, busy, done);
    end
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({first_we, second_we, busy, done} !== 4'b0) begin
      failures++;
      $display("FAIL idle_after_reset: we=%b%b busy=%b done=%b, required 0000",
               first_we, second_we, busy, done);
    end
  endtask

  // One complete octave with a given image pattern; optional stray starts
  task automatic test_octave(input string name, input int pattern, input bit poke);
    int s;
    bit ok;
    fill(pattern);
    wq.delete();
    done_q.delete();
    @(negedge clk);
    start = 1'b1;
    s = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_on_start: got %b, required 1", name, busy);
    end
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      start = poke && (edge_cnt == s + 5 || edge_cnt == s + 17);
      if (done_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s done_timeout: no done within 60 cycles", name);
    end
    checks++;
    if (wq.size() != N) begin
      failures++;
      $display("FAIL %s write_count: got %0d, required %0d", name, wq.size(), N);
    end
    for (int i = 0; i < wq.size() && i < N; i++) begin
      checks++;
      if (wq[i].addr != i || wq[i].addr2 != i || !wq[i].both ||
          wq[i].cyc != s + i + RL + 1 ||
          wq[i].d1 != exp_diff(int'(m1[i]), int'(m0[i])) ||
          wq[i].d2 != exp_diff(int'(m2[i]), int'(m1[i]))) begin
        failures++;
        $display("FAIL %s write[%0d]: addr=%0d/%0d both=%b edge=%0d d1=%0d d2=%0d, required addr=%0d edge=%0d d1=%0d d2=%0d",
                 name, i, wq[i].addr, wq[i].addr2, wq[i].both, wq[i].cyc,
                 wq[i].d1, wq[i].d2, i, s + i + RL + 1,
                 exp_diff(int'(m1[i]), int'(m0[i])),
                 exp_diff(int'(m2[i]), int'(m1[i])));
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != s + N + RL + 1) begin
      failures++;
      $display("FAIL %s done_pulse: count=%0d edge=%0d, required count=1 edge=%0d",
               name, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1,
               s + N + RL + 1);
    end
    checks++;
    if (busy !== 1'b0 || gauss_address !== 4'(N - 1)) begin
      failures++;
      $display("FAIL %s after_run: busy=%b ga=%0d, required busy=0 ga=%0d",
               name, busy, gauss_address, N - 1);
    end
  endtask

  task automatic test_reset_mid;
    bit hit;
    fill(2);
    wq.delete();
    done_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (first_we === 1'b1 && first_address === 4'd7) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL reset_mid_reach: write of address 7 not seen within 40 cycles");
    end
    rst_in = 1'b1;
    @(negedge clk);
    checks++;
    if ({first_we, second_we, busy, done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_abort: we=%b%b busy=%b done=%b, required 0000",
               first_we, second_we, busy, done);
    end
    rst_in = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (done_q.size() != 0 || wq.size() != 8) begin
      failures++;
      $display("FAIL reset_mid_quiet: dones=%0d writes=%0d, required dones=0 writes=8",
               done_q.size(), wq.size());
    end
    test_octave("restart", 2, 1'b0);
  endtask

  task automatic test_back_to_back;
    int s1, s2;
    bit ok;
    fill(2);
    wq.delete();
    done_q.delete();
    @(negedge clk);
    start = 1'b1;
    s1 = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    start = 1'b1;
    s2 = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60 && done_q.size() < 2; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || done_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_done: first_seen=%b dones=%0d, required 1 and 2", ok, done_q.size());
    end else begin
      checks++;
      if (done_q[1] != s2 + N + RL + 1) begin
        failures++;
        $display("FAIL b2b_done_edge: got %0d, required %0d", done_q[1], s2 + N + RL + 1);
      end
    end
    checks++;
    if (wq.size() != 2 * N) begin
      failures++;
      $display("FAIL b2b_write_count: got %0d, required %0d", wq.size(), 2 * N);
    end
    for (int i = 0; i < wq.size() && i < 2 * N; i++) begin
      int a, s;
      a = i % N;
      s = (i < N) ? s1 : s2;
      checks++;
      if (wq[i].addr != a || wq[i].cyc != s + a + RL + 1 ||
          wq[i].d1 != exp_diff(int'(m1[a]), int'(m0[a])) ||
          wq[i].d2 != exp_diff(int'(m2[a]), int'(m1[a]))) begin
        failures++;
        $display("FAIL b2b_write[%0d]: addr=%0d edge=%0d d1=%0d d2=%0d, required addr=%0d edge=%0d d1=%0d d2=%0d",
                 i, wq[i].addr, wq[i].cyc, wq[i].d1, wq[i].d2, a, s + a + RL + 1,
                 exp_diff(int'(m1[a]), int'(m0[a])), exp_diff(int'(m2[a]), int'(m1[a])));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < N; a++) begin
      m0[a] = '0;
      m1[a] = '0;
      m2[a] = '0;
    end
    test_reset();
    test_octave("ramp", 0, 1'b0);
    test_octave("extremes", 1, 1'b0);
    test_octave("random", 2, 1'b0);
    test_octave("small_diffs", 3, 1'b0);
    test_octave("start_ignored", 2, 1'b1);
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
